shift_cmd_sequencer: RTL and testbench
======================================

SHIFT_CMD_SEQUENCER -- requirements
Module: shift_cmd_sequencer

Interface
REQ-001 Parameter CNT_W, default 4, width of the shift-step count; a command may request 0..2^CNT_W-1 steps.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  sequencer accepts a command this cycle.
REQ-006 cmd_data  input  4  value to load into the shift register.
REQ-007 cmd_op  input  2  shift operation: 00 shift left, 01 shift right, 10 rotate left, 11 rotate right.
REQ-008 cmd_cnt  input  CNT_W  number of shift steps after the load.
REQ-009 load  output  1  drives the shift register load input.
REQ-010 sel  output  2  drives the shift register operation select.
REQ-011 ip  output  4  drives the shift register parallel input.
REQ-012 busy  output  1  a command is in progress (LOAD or SHIFT state).
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 shadow  output  4  model of the downstream register value; after every clock edge it SHALL equal the downstream op.

Function
REQ-015 The FSM SHALL have four states: IDLE, LOAD, SHIFT, DONE; all outputs are Moore (decoded from registered state only).
REQ-016 A handshake occurs on a rising edge with cmd_valid=1 and cmd_ready=1; cmd_ready=1 only in IDLE.
REQ-017 On handshake: capture cmd_data, cmd_op and cmd_cnt; IDLE -> LOAD.
REQ-018 In LOAD: load=1, ip=captured data; at the edge, shadow <= data and remaining <= cnt; next state SHIFT if cnt != 0, else DONE.
REQ-019 In SHIFT: load=0, sel=captured op; at each edge, shadow is updated per op (zero fill for shifts) and remaining decrements; SHIFT -> DONE at the edge where remaining==1.
REQ-020 In DONE: done=1 for exactly one cycle; DONE -> IDLE unconditionally.
REQ-021 In IDLE and DONE: load=1, ip=shadow, sel=00, so the downstream register reloads its own value and holds.
REQ-022 busy=1 exactly in LOAD and SHIFT.
REQ-023 Latency: done is asserted cnt+2 cycles after the handshake edge (1 LOAD, cnt SHIFT, then DONE).
REQ-024 cmd_valid while cmd_ready=0 SHALL be ignored; the captured command SHALL NOT change mid-operation.
REQ-025 The count SHALL be treated as unsigned; cnt = 2^CNT_W-1 SHALL execute exactly that many steps with no wrap.

Reset
REQ-026 When rst=0, asynchronously: state=IDLE, shadow=0, remaining=0, captured registers=0.
REQ-027 While in reset: load=1, ip=0, sel=00, done=0, busy=0, cmd_ready=1.
REQ-028 Reset asserted in any state SHALL abort the command with no done pulse; the first handshake after release is accepted normally.

Verification
REQ-029 Handshake data=1011, op=00, cnt=2 -> LOAD, SHIFT, SHIFT, DONE; shadow 1011 -> 0110 -> 1100; done high in the 4th cycle after the handshake.
REQ-030 data=1001, op=10, cnt=4 -> shadow 0011, 0110, 1100, 1001; final shadow=1001, matching downstream op.
REQ-031 data=0110, cnt=0 -> LOAD then DONE; done in the 2nd cycle after the handshake; shadow=0110.
REQ-032 cmd_valid held high with a 2nd command during SHIFT -> cmd_ready=0; the 2nd command is accepted on the first IDLE edge after DONE.
REQ-033 rst=0 asserted mid-SHIFT (op=11) -> immediately IDLE, shadow=0, load=1, ip=0, no done pulse.
REQ-034 After done, 10 idle cycles with cmd_valid=0 -> load=1, ip=shadow every cycle; downstream op and shadow unchanged.

Source files
------------

// File: rtl/shift_cmd_sequencer.sv
// Command sequencer for a 4-bit universal shift register: loads a value, then
// issues a counted series of shift/rotate steps while tracking the result in shadow.
module shift_cmd_sequencer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_data,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic             load,
  output logic [1:0]       sel,
  output logic [3:0]       ip,
  output logic             busy,
  output logic             done,
  output logic [3:0]       shadow
);

  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] data_q;
  logic [1:0]        op_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  remaining;

  // One step of the downstream register; shifts fill with zero.
  function automatic logic [DATA_W-1:0] shift_step(input logic [DATA_W-1:0] v,
                                                   input logic [1:0] op);
    logic [DATA_W-1:0] r;
    case (op)
      2'b00:   r = {v[DATA_W-2:0], 1'b0};
      2'b01:   r = {1'b0, v[DATA_W-1:1]};
      2'b10:   r = {v[DATA_W-2:0], v[DATA_W-1]};
      default: r = {v[0], v[DATA_W-1:1]};
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      data_q    <= '0;
      op_q      <= '0;
      cnt_q     <= '0;
      remaining <= '0;
      shadow    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            data_q <= cmd_data;
            op_q   <= cmd_op;
            cnt_q  <= cmd_cnt;
          end
        end
        LOAD: begin
          shadow    <= data_q;
          remaining <= cnt_q;
        end
        SHIFT: begin
          shadow    <= shift_step(shadow, op_q);
          remaining <= remaining - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Outside LOAD/SHIFT the register is reloaded with its own value so it holds.
  always_comb begin
    state_nxt = state;
    load      = 1'b1;
    sel       = 2'b00;
    ip        = shadow;
    busy      = 1'b0;
    done      = 1'b0;
    cmd_ready = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = LOAD;
      end
      LOAD: begin
        ip        = data_q;
        busy      = 1'b1;
        state_nxt = (cnt_q != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        load = 1'b0;
        sel  = op_q;
        busy = 1'b1;
        if (remaining == CNT_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Self-checking bench for shift_cmd_sequencer: scoreboard of completion latency and
// final value, a downstream register model, and per-scenario inline checks.
module tb_shift_cmd_sequencer;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_data;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic             load;
  logic [1:0]       sel;
  logic [3:0]       ip;
  logic             busy;
  logic             done;
  logic [3:0]       shadow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rst_q;
  logic [3:0] ds;
  logic [3:0] last_final;

  typedef struct {
    int         due;
    logic [3:0] val;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  shift_cmd_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_op(cmd_op), .cmd_cnt(cmd_cnt),
    .load(load), .sel(sel), .ip(ip), .busy(busy), .done(done), .shadow(shadow)
  );

  function automatic logic [3:0] model_step(input logic [3:0] v, input logic [1:0] op);
    case (op)
      2'b00:   return {v[2:0], 1'b0};
      2'b01:   return {1'b0, v[3:1]};
      2'b10:   return {v[2:0], v[3]};
      default: return {v[0], v[3:1]};
    endcase
  endfunction

  function automatic logic [3:0] model_final(input logic [3:0] d, input logic [1:0] op,
                                             input int n);
    logic [3:0] v = d;
    for (int i = 0; i < n; i++) v = model_step(v, op);
    return v;
  endfunction

  // Downstream shift register driven by the sequencer outputs.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
    ds    <= load ? ip : model_step(ds, sel);
  end

  // Scoreboard: handshake pushes expected done time and value; done pops it.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      sbq.delete();
    end else begin
      if (rst_q === 1'b1) begin
        checks++;
        if (ds !== shadow) begin
          errors++;
          $display("FAIL shadow_vs_downstream cyc=%0d got %b want %b", cyc, shadow, ds);
        end
      end
      if (done === 1'b1) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done cyc=%0d got done=1 want done=0", cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if (cyc != e.due || shadow !== e.val) begin
            errors++;
            $display("FAIL done_result got cyc=%0d shadow=%b want cyc=%0d shadow=%b",
                     cyc, shadow, e.due, e.val);
          end
        end
      end
      if (cmd_valid === 1'b1 && cmd_ready === 1'b1)
        sbq.push_back('{due: cyc + int'(cmd_cnt) + 2,
                        val: model_final(cmd_data, cmd_op, int'(cmd_cnt))});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers a command and returns #1 after the handshake edge (first LOAD cycle).
  task automatic send(input logic [3:0] d, input logic [1:0] op, input logic [CNT_W-1:0] n);
    bit ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_op    = op;
    cmd_cnt   = n;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (cmd_ready === 1'b1) ok = 1'b1;
      step();
    end
    cmd_valid  = 1'b0;
    last_final = model_final(d, op, int'(n));
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got cmd_ready=%b want 1", cmd_ready);
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout got cmd_ready=%b want 1", cmd_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; cmd_valid = 1'b0; cmd_data = '0; cmd_op = '0; cmd_cnt = '0;
    repeat (3) step();
    checks++;
    if ({load, sel, ip, busy, done, cmd_ready} !== {1'b1, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_outputs got %b want %b",
               {load, sel, ip, busy, done, cmd_ready}, 10'b1000000001);
    end
    checks++;
    if (shadow !== 4'b0000) begin
      errors++;
      $display("FAIL reset_shadow got %b want 0000", shadow);
    end
    rst = 1'b1;
    step();
    checks++;
    if (cmd_ready !== 1'b1 || shadow !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle got ready=%b shadow=%b busy=%b want 1 0000 0",
               cmd_ready, shadow, busy);
    end
  endtask

  task automatic test_shift_left();
    logic [3:0] exp_sh [3];
    exp_sh[0] = 4'b1011; exp_sh[1] = 4'b0110; exp_sh[2] = 4'b1100;
    wait_idle();
    send(4'b1011, 2'b00, CNT_W'(2));
    checks++;
    if ({busy, load, ip, cmd_ready, done} !== {1'b1, 1'b1, 4'b1011, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sl_load_cycle got %b want %b", {busy, load, ip, cmd_ready, done}, 8'b11101100);
    end
    for (int c = 2; c <= 4; c++) begin
      step();
      checks++;
      if (shadow !== exp_sh[c-2]) begin
        errors++;
        $display("FAIL sl_shadow cycle=%0d got %b want %b", c, shadow, exp_sh[c-2]);
      end
      checks++;
      if (c < 4 && {load, sel, done} !== 4'b0000) begin
        errors++;
        $display("FAIL sl_shift_ctrl cycle=%0d got %b want 0000", c, {load, sel, done});
      end else if (c == 4 && {done, busy, load, ip} !== {1'b1, 1'b0, 1'b1, 4'b1100}) begin
        errors++;
        $display("FAIL sl_done_cycle got %b want 1011100", {done, busy, load, ip});
      end
    end
    step();
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL sl_after_done got done=%b ready=%b want 0 1", done, cmd_ready);
    end
  endtask

  task automatic test_rotate();
    logic [3:0] exp;
    wait_idle();
    send(4'b1001, 2'b10, CNT_W'(4));
    exp = 4'b1001;
    for (int c = 2; c <= 6; c++) begin
      step();
      checks++;
      if (shadow !== exp) begin
        errors++;
        $display("FAIL rotl_shadow cycle=%0d got %b want %b", c, shadow, exp);
      end
      checks++;
      if (c < 6 && {sel, load, done} !== 4'b1000) begin
        errors++;
        $display("FAIL rotl_ctrl cycle=%0d got %b want 1000", c, {sel, load, done});
      end else if (c == 6 && done !== 1'b1) begin
        errors++;
        $display("FAIL rotl_done got %b want 1", done);
      end
      if (c < 6) exp = model_step(exp, 2'b10);
    end
    step();
  endtask

  task automatic test_zero_cnt();
    wait_idle();
    send(4'b0110, 2'b01, CNT_W'(0));
    checks++;
    if ({busy, load, ip} !== {1'b1, 1'b1, 4'b0110}) begin
      errors++;
      $display("FAIL zc_load got %b want 110110", {busy, load, ip});
    end
    step();
    checks++;
    if ({done, busy, shadow} !== {1'b1, 1'b0, 4'b0110}) begin
      errors++;
      $display("FAIL zc_done got %b want 100110", {done, busy, shadow});
    end
    step();
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL zc_after got done=%b ready=%b want 0 1", done, cmd_ready);
    end
  endtask

  task automatic test_back_to_back();
    wait_idle();
    send(4'b0101, 2'b00, CNT_W'(3));
    cmd_valid = 1'b1; cmd_data = 4'b1110; cmd_op = 2'b11; cmd_cnt = CNT_W'(1);
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) step();
      checks++;
      if (cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_ready_busy cycle=%0d got %b want 0", c, cmd_ready);
      end
    end
    step();
    checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got ready=%b done=%b want 1 0", cmd_ready, done);
    end
    step();
    cmd_valid  = 1'b0;
    last_final = model_final(4'b1110, 2'b11, 1);
    checks++;
    if ({busy, load, ip} !== {1'b1, 1'b1, 4'b1110}) begin
      errors++;
      $display("FAIL b2b_second_load got %b want 111110", {busy, load, ip});
    end
    wait_idle();
    checks++;
    if (shadow !== 4'b0111) begin
      errors++;
      $display("FAIL b2b_final got %b want 0111", shadow);
    end
  endtask

  task automatic test_max_cnt();
    int n = 1;
    wait_idle();
    send(4'b1000, 2'b10, CNT_W'((1 << CNT_W) - 1));
    while (done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n != (1 << CNT_W) + 1 || shadow !== 4'b0100) begin
      errors++;
      $display("FAIL max_cnt got cycle=%0d shadow=%b want cycle=%0d shadow=0100",
               n, shadow, (1 << CNT_W) + 1);
    end
    step();
  endtask

  task automatic test_idle_hold();
    logic [3:0] hold;
    wait_idle();
    hold = last_final;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({load, ip, shadow, ds} !== {1'b1, hold, hold, hold}) begin
        errors++;
        $display("FAIL idle_hold i=%0d got load=%b ip=%b shadow=%b ds=%b want 1 %b",
                 i, load, ip, shadow, ds, hold);
      end
    end
  endtask

  task automatic test_reset_mid();
    wait_idle();
    send(4'b1101, 2'b11, CNT_W'(5));
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({shadow, load, ip, busy, done, cmd_ready, sel} !==
        {4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 2'b00}) begin
      errors++;
      $display("FAIL mid_reset got %b want 00001000000100",
               {shadow, load, ip, busy, done, cmd_ready, sel});
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (done !== 1'b0 || shadow !== 4'b0000) begin
        errors++;
        $display("FAIL mid_reset_hold got done=%b shadow=%b want 0 0000", done, shadow);
      end
    end
    rst = 1'b1;
    send(4'b0011, 2'b10, CNT_W'(1));
    wait_idle();
    checks++;
    if (shadow !== 4'b0110) begin
      errors++;
      $display("FAIL after_reset_cmd got %b want 0110", shadow);
    end
  endtask

  initial begin
    test_reset();
    test_shift_left();
    test_rotate();
    test_zero_cnt();
    test_back_to_back();
    test_max_cnt();
    test_idle_hold();
    test_reset_mid();
    repeat (3) step();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL pending_commands got %0d want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
